// File: rtl/id_ex_stage.sv
`default_nettype none
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush
// handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_PCSrc,
  input  logic [1:0]       id_RegDst,
  input  logic [1:0]       id_MemToReg,
  input  logic [5:0]       id_ALUFun,
  input  logic [8:0]       id_ctrl,
  input  logic [31:0]      id_pc_plus4,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm32,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  input  logic             flush,
  output logic             stall,
  output logic [2:0]       ex_PCSrc,
  output logic [1:0]       ex_RegDst,
  output logic [1:0]       ex_MemToReg,
  output logic [5:0]       ex_ALUFun,
  output logic [8:0]       ex_ctrl,
  output logic [31:0]      ex_pc_plus4,
  output logic [31:0]      ex_rs_data,
  output logic [31:0]      ex_rt_data,
  output logic [31:0]      ex_imm32,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_shamt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int BUNDLE_W = 3 + 2 + 2 + 6 + 9 + 4 * 32 + 4 * 5;
  localparam int MEMRD_BIT = 3;

  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                load_use;
  logic                bubble;

  assign bundle_d = {id_PCSrc, id_RegDst, id_MemToReg, id_ALUFun, id_ctrl,
                     id_pc_plus4, id_rs_data, id_rt_data, id_imm32,
                     id_rs, id_rt, id_rd, id_shamt};

  assign {ex_PCSrc, ex_RegDst, ex_MemToReg, ex_ALUFun, ex_ctrl,
          ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm32,
          ex_rs, ex_rt, ex_rd, ex_shamt} = bundle_q;

  // Conservative: both source fields are compared whatever the instruction format.
  assign load_use = ex_ctrl[MEMRD_BIT] & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign stall    = load_use & ~flush & reset;
  assign bubble   = flush | load_use;
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bundle_q <= '0;
      cnt_q    <= '0;
    end else if (bubble) begin
      bundle_q <= '0;
      cnt_q    <= cnt_d;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Scoreboard bench for id_ex_stage: directed test-plan sequences followed by
// randomized traffic, checked against a behavioural pipeline model.
module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [2:0]  pcsrc;
    logic [1:0]  regdst;
    logic [1:0]  m2r;
    logic [5:0]  alufun;
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
  } instr_t;

  typedef struct {
    bit     stall;
    instr_t ex;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fl = 1'b0;
  instr_t cur = '0;

  logic stall;
  instr_t act;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n),
    .id_PCSrc(cur.pcsrc), .id_RegDst(cur.regdst), .id_MemToReg(cur.m2r),
    .id_ALUFun(cur.alufun), .id_ctrl(cur.ctrl), .id_pc_plus4(cur.pc),
    .id_rs_data(cur.rs_d), .id_rt_data(cur.rt_d), .id_imm32(cur.imm),
    .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd), .id_shamt(cur.sh),
    .flush(fl), .stall(stall),
    .ex_PCSrc(act.pcsrc), .ex_RegDst(act.regdst), .ex_MemToReg(act.m2r),
    .ex_ALUFun(act.alufun), .ex_ctrl(act.ctrl), .ex_pc_plus4(act.pc),
    .ex_rs_data(act.rs_d), .ex_rt_data(act.rt_d), .ex_imm32(act.imm),
    .ex_rs(act.rs), .ex_rt(act.rt), .ex_rd(act.rd), .ex_shamt(act.sh),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  instr_t m_ex = '0;
  int     m_cnt = 0;
  bit     last_stall = 0;

  // Reference: what EX holds is either the previous ID instruction or a bubble.
  task automatic step(input instr_t in, input bit f, input bit rn);
    exp_t e;
    bit   is_load, hazard;
    @(posedge clk);
    #1;
    cur = in; fl = f; rst_n = rn;
    is_load = (m_ex.ctrl[3] == 1'b1);
    hazard  = is_load && (m_ex.rt != 0) && (m_ex.rt == in.rs || m_ex.rt == in.rt);
    e.stall = hazard && !f && rn;
    if (!rn) begin
      m_ex = '0; m_cnt = 0;
    end else if (f || hazard) begin
      m_ex = '0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_ex = in;
    end
    e.ex = m_ex; e.cnt = m_cnt;
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  function automatic instr_t rnd_instr();
    instr_t r;
    r.pcsrc = 3'($urandom); r.regdst = 2'($urandom); r.m2r = 2'($urandom);
    r.alufun = 6'($urandom); r.ctrl = 9'($urandom);
    r.pc = $urandom; r.rs_d = $urandom; r.rt_d = $urandom; r.imm = $urandom;
    r.rs = 5'($urandom_range(0, 3)); r.rt = 5'($urandom_range(0, 3));
    r.rd = 5'($urandom); r.sh = 5'($urandom);
    r.ctrl[3] = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  function automatic instr_t mk(input logic [8:0] ctrl, input logic [4:0] rs,
                                input logic [4:0] rt);
    instr_t r = rnd_instr();
    r.ctrl = ctrl; r.rs = rs; r.rt = rt;
    return r;
  endfunction

  // Monitor: stall is checked in the cycle the inputs are applied, EX outputs
  // and the counter one edge later.
  initial begin : monitor
    exp_t pend;
    bit   have = 0;
    forever begin
      @(negedge clk);
      if (have) begin
        total++;
        if (act !== pend.ex) begin
          bad++;
          $display("FAIL ex_bundle t=%0t actual=%h required=%h", $time, act, pend.ex);
        end
        total++;
        if (bubble_cnt !== CNT_W'(pend.cnt)) begin
          bad++;
          $display("FAIL bubble_cnt t=%0t actual=%0d required=%0d", $time, bubble_cnt, pend.cnt);
        end
        have = 0;
      end
      if (sb.size() > 0) begin
        pend = sb.pop_front();
        have = 1;
        total++;
        if (stall !== pend.stall) begin
          bad++;
          $display("FAIL stall t=%0t actual=%b required=%b", $time, stall, pend.stall);
        end
      end
    end
  end

  initial begin : driver
    instr_t i;
    instr_t held;
    // Reset with random inputs, then release with ALUFun=1, RegWr=1.
    step(rnd_instr(), 1'b0, 1'b0);
    step(rnd_instr(), 1'b1, 1'b0);
    i = mk(9'h100, 5'd1, 5'd2); i.alufun = 6'b000001;
    step(i, 1'b0, 1'b1);
    // Load-use: lw rt=8 then add rs=8, rt=9 (presented twice, as IF/ID holds).
    step(mk(9'h108, 5'd1, 5'd8), 1'b0, 1'b1);
    i = mk(9'h100, 5'd8, 5'd9);
    step(i, 1'b0, 1'b1);
    step(i, 1'b0, 1'b1);
    // No false hazard: lw to $0, and a non-load writing rt=8.
    step(mk(9'h108, 5'd3, 5'd0), 1'b0, 1'b1);
    step(mk(9'h100, 5'd0, 5'd4), 1'b0, 1'b1);
    step(mk(9'h100, 5'd3, 5'd8), 1'b0, 1'b1);
    step(mk(9'h100, 5'd8, 5'd5), 1'b0, 1'b1);
    // Flush of a beq.
    i = mk(9'h000, 5'd6, 5'd7); i.pcsrc = 3'b001;
    step(i, 1'b1, 1'b1);
    // Simultaneous flush and load-use.
    step(mk(9'h108, 5'd1, 5'd8), 1'b0, 1'b1);
    step(mk(9'h100, 5'd8, 5'd9), 1'b1, 1'b1);
    // Interrupt and RegDst=11 pass through a normal cycle.
    i = mk(9'h101, 5'd10, 5'd11); i.regdst = 2'b11;
    step(i, 1'b0, 1'b1);
    // Counter saturation.
    for (int k = 0; k < 20; k++) step(rnd_instr(), 1'b1, 1'b1);
    step(mk(9'h100, 5'd1, 5'd2), 1'b0, 1'b1);
    // Random traffic; a stalled ID instruction is re-presented.
    step(rnd_instr(), 1'b0, 1'b0);
    held = rnd_instr();
    for (int k = 0; k < 400; k++) begin
      if (!last_stall) held = rnd_instr();
      step(held, ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline. Sits directly downstream of the instruction decoder (Control) and register file, and feeds the EX stage.
- Latches the decoded control bundle and operand data every cycle.
- Detects load-use hazards, asserting a stall to PC/IF-ID and inserting a bubble into EX.
- Kills the ID instruction on an EX-resolved flush.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_PCSrc  in  3  decoder PC source select.
- id_RegDst  in  2  decoder destination-register select.
- id_MemToReg  in  2  decoder writeback select.
- id_ALUFun  in  6  decoder ALU function.
- id_ctrl  in  9  {RegWr,ALUSrc1,ALUSrc2,Sign,MemWr,MemRd,EXTOp,LUOp,Interrupt}, MSB first.
- id_pc_plus4  in  32  PC+4 of the ID instruction.
- id_rs_data  in  32  register file read data A.
- id_rt_data  in  32  register file read data B.
- id_imm32  in  32  extended immediate.
- id_rs  in  5  rs field.
- id_rt  in  5  rt field.
- id_rd  in  5  rd field.
- id_shamt  in  5  shift amount.
- flush  in  1  EX resolved a taken branch, jump or exception; kill the ID instruction.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_PCSrc, ex_RegDst, ex_MemToReg, ex_ALUFun, ex_ctrl  out  3/2/2/6/9  registered copies of the id_* control fields.
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm32  out  32 each  registered copies of the id_* data fields.
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each  registered copies of the id_* register fields.
- bubble_cnt  out  CNT_W  count of bubbles inserted (load-use and flush), saturating.

Behaviour:
- All registered outputs update on the rising edge of clk only.
- Reset (reset==0 at a clk edge): every ex_* output is cleared to 0 and bubble_cnt is cleared to 0. A bubble is an all-zero bundle: RegWr=0, MemWr=0, MemRd=0, Interrupt=0, PCSrc=000.
  - Reset asserted mid-stall or mid-flush overrides both; the first cycle after reset is a bubble in EX.
- Load-use hazard (combinational): load_use = ex_ctrl.MemRd & (ex_rt!=0) & ((ex_rt==id_rs) | (ex_rt==id_rt)).
  - The comparison is conservative; rs and rt are always compared, regardless of instruction format.
- stall = load_use & ~flush & reset.
  - stall is forced to 0 while reset is low.
- Per-edge priority when reset==1:
  1. flush==1: load the bubble (all ex_* = 0). The ID instruction is discarded, including a pending Interrupt. The interrupt controller re-asserts IRQ because it is level-sensitive.
  2. load_use==1 (and flush==0): load the bubble. PC and IF/ID hold via stall, so the same ID instruction is re-presented next cycle and captured then. That next cycle has no hazard, because EX now holds a bubble with MemRd=0.
  3. Otherwise: capture all id_* inputs into the ex_* outputs.
- Latency: 1 cycle from ID inputs to EX outputs; a load-use adds exactly one bubble.
- bubble_cnt increments by 1 on every edge where case 1 or case 2 applies. It saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous flush and load_use: flush wins, stall=0, and bubble_cnt counts +1 (not +2).
- No other state; the block never stalls for more than one consecutive cycle on its own.

Test Plan:
- Reset: reset=0 for 2 cycles with random inputs -> all ex_* = 0, bubble_cnt=0, stall=0. Release reset with id_ALUFun=6'b000001, id_ctrl RegWr=1 -> ex_ALUFun=6'b000001 and ex RegWr=1 one cycle later.
- Load-use: EX holds lw with ex_rt=8, MemRd=1; ID has add with rs=8, rt=9 ->
  - stall=1 that cycle;
  - next edge: ex_* = 0, bubble_cnt=1;
  - following edge: add captured (ex_rs=8), stall=0.
- No false hazard:
  - lw with ex_rt=0 and id_rs=0 -> stall=0, normal capture;
  - ex_rt=8 with MemRd=0 and id_rs=8 -> stall=0.
- Flush: flush=1 with ID instruction beq (PCSrc=001) -> next ex_PCSrc=000, ex RegWr=0, bubble_cnt+1.
- Simultaneous: flush=1 and load_use=1 -> stall=0, one bubble, bubble_cnt increments by exactly 1.
- Saturation: CNT_W=4, force 20 flush cycles -> bubble_cnt stops at 15. Interrupt=1 captured during a normal cycle -> ex_ctrl Interrupt=1 and ex_RegDst=2'b11 pass through unchanged.
